// File: rtl/reg_wb_queue_pkg.sv
// Shared processor definitions for the register-bank write path.
// Holds the register-bank geometry, the default depth of the pending-write
// queue and the {rd, data} record stored in each queue entry.
package reg_wb_queue_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 16;
  localparam int WBQ_DEPTH   = 4;

  // One pending register write: destination index plus value.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-wins match over an age-ordered list of pending writes.
// Ports:
//   cand_rd/cand_data/cand_vld : N candidates, index 0 oldest, N-1 youngest
//   idx                        : register index being looked up
//   hit                        : some valid candidate targets idx
//   data                       : value of the youngest such candidate, else 0
module wbq_fwd_match
  import reg_wb_queue_pkg::*;
#(
  parameter int N      = WBQ_DEPTH + 1,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic [N-1:0][ADDR_W-1:0] cand_rd,
  input  logic [N-1:0][DATA_W-1:0] cand_data,
  input  logic [N-1:0]             cand_vld,
  input  logic [ADDR_W-1:0]        idx,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Scanning oldest to youngest lets a later match overwrite an earlier
  // one, so the youngest matching entry is what remains.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_vld[i] && (cand_rd[i] == idx)) begin
        hit  = 1'b1;
        data = cand_data[i];
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Pending register write-back queue with operand forwarding.
// Results from execute are queued in order and drained one per cycle into
// the register bank through a registered write stage. Operand reads ra/rb
// are matched against every write not yet committed to the bank.
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   res_valid/res_ready          : result handshake from execute
//   res_rd/res_data              : offered result destination and value
//   wr_stall                     : bank write port busy, hold the drain
//   we/rd/wd                     : registered write to the register bank
//   ra/rb                        : operand indices read from the bank
//   fwd_a_hit/fwd_a_data (b too) : youngest pending value for ra / rb
//   count                        : entries in the queue (not the write stage)
// The entry record comes from the shared package, so DATA_W and ADDR_W
// must match the package register-bank widths.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [ADDR_W-1:0]          res_rd,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       wr_stall,
  output logic                       we,
  output logic [ADDR_W-1:0]          rd,
  output logic [DATA_W-1:0]          wd,
  input  logic [ADDR_W-1:0]          ra,
  input  logic [ADDR_W-1:0]          rb,
  output logic                       fwd_a_hit,
  output logic [DATA_W-1:0]          fwd_a_data,
  output logic                       fwd_b_hit,
  output logic [DATA_W-1:0]          fwd_b_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NCAND = DEPTH + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   head_p0;
  logic [PTR_W-1:0]   tail_p0;
  logic [CNT_W-1:0]   count_p0;

  logic               vld_p1;
  logic [ADDR_W-1:0]  rd_p1;
  logic [DATA_W-1:0]  wd_p1;

  logic               push;
  logic               pop;

  // Ready depends on registered occupancy only; a pop in the same cycle
  // does not open a slot for the offered result.
  assign res_ready = (count_p0 < CNT_W'(DEPTH));
  assign push      = res_valid && res_ready;
  assign pop       = (count_p0 != '0) && !wr_stall;

  // Stage p0: queue storage. Entries are not reset; occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_p0] <= '{rd: res_rd, data: res_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else begin
      if (push) tail_p0 <= tail_p0 + 1'b1;
      if (pop)  head_p0 <= head_p0 + 1'b1;
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // Stage p1: bank write stage. Index and data hold while no write issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      rd_p1  <= '0;
      wd_p1  <= '0;
    end else if (pop) begin
      vld_p1 <= 1'b1;
      rd_p1  <= mem[head_p0].rd;
      wd_p1  <= mem[head_p0].data;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign we    = vld_p1;
  assign rd    = rd_p1;
  assign wd    = wd_p1;
  assign count = count_p0;

  // Candidates in age order: slot 0 is the write stage (oldest), then queue
  // entries from head to tail. Only occupied slots are marked valid.
  logic [NCAND-1:0][ADDR_W-1:0] cand_rd;
  logic [NCAND-1:0][DATA_W-1:0] cand_data;
  logic [NCAND-1:0]             cand_vld;

  always_comb begin
    cand_rd      = '0;
    cand_data    = '0;
    cand_vld     = '0;
    cand_rd[0]   = rd_p1;
    cand_data[0] = wd_p1;
    cand_vld[0]  = vld_p1;
    for (int k = 0; k < DEPTH; k++) begin
      cand_rd[k+1]   = mem[head_p0 + PTR_W'(k)].rd;
      cand_data[k+1] = mem[head_p0 + PTR_W'(k)].data;
      cand_vld[k+1]  = (CNT_W'(k) < count_p0);
    end
  end

  wbq_fwd_match #(.N(NCAND), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_a (
    .cand_rd   (cand_rd),
    .cand_data (cand_data),
    .cand_vld  (cand_vld),
    .idx       (ra),
    .hit       (fwd_a_hit),
    .data      (fwd_a_data)
  );

  wbq_fwd_match #(.N(NCAND), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_b (
    .cand_rd   (cand_rd),
    .cand_data (cand_data),
    .cand_vld  (cand_vld),
    .idx       (rb),
    .hit       (fwd_b_hit),
    .data      (fwd_b_data)
  );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed scenarios followed by random traffic,
// checked against an in-order queue model of pending writes.
module tb_reg_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_rd;
  logic [DATA_W-1:0] res_data;
  logic              wr_stall;
  logic              we;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic              fwd_a_hit;
  logic [DATA_W-1:0] fwd_a_data;
  logic              fwd_b_hit;
  logic [DATA_W-1:0] fwd_b_data;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .wr_stall   (wr_stall),
    .we         (we),
    .rd         (rd),
    .wd         (wd),
    .ra         (ra),
    .rb         (rb),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data),
    .count      (count)
  );

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference: pending writes in arrival order, plus the last bank write.
  ent_t              q[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_wd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest uncommitted write to idx: newest queue entry first, then the
  // write currently presented to the bank.
  function automatic void model_fwd(input logic [ADDR_W-1:0] idx,
                                    output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].rd == idx) begin
        hit = 1'b1;
        d   = q[i].data;
        return;
      end
    end
    if (m_we && (m_rd == idx)) begin
      hit = 1'b1;
      d   = m_wd;
    end
  endfunction

  task automatic step(input logic rn, input logic v, input logic [ADDR_W-1:0] r,
                      input logic [DATA_W-1:0] d, input logic st,
                      input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                      input bit check);
    logic              eh;
    logic [DATA_W-1:0] ed;
    ent_t              e;
    bit                do_push;
    rst       = rn;
    res_valid = v;
    res_rd    = r;
    res_data  = d;
    wr_stall  = st;
    ra        = a;
    rb        = b;
    #1;
    if (check) begin
      chk("res_ready", 32'(res_ready), 32'(q.size() < DEPTH));
      chk("count",     32'(count),     32'(q.size()));
      chk("we",        32'(we),        32'(m_we));
      chk("rd",        32'(rd),        32'(m_rd));
      chk("wd",        32'(wd),        32'(m_wd));
      model_fwd(a, eh, ed);
      chk("fwd_a_hit",  32'(fwd_a_hit),  32'(eh));
      chk("fwd_a_data", 32'(fwd_a_data), 32'(ed));
      model_fwd(b, eh, ed);
      chk("fwd_b_hit",  32'(fwd_b_hit),  32'(eh));
      chk("fwd_b_data", 32'(fwd_b_data), 32'(ed));
    end
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_we = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      do_push = v && (q.size() < DEPTH);
      if (q.size() != 0 && !st) begin
        e    = q.pop_front();
        m_we = 1'b1;
        m_rd = e.rd;
        m_wd = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (do_push) begin
        e.rd   = r;
        e.data = d;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; res_valid = 1'b0; res_rd = '0; res_data = '0;
    wr_stall = 1'b0; ra = '0; rb = '0;
    m_we = 1'b0; m_rd = '0; m_wd = '0;
    @(negedge clk);

    // Reset, then check the post-reset state.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Single write and its latency.
    step(1, 1, 3, 16'hA5A5, 0, 3, 3, 1);
    step(1, 0, 0, 16'h0000, 0, 3, 3, 1);
    step(1, 0, 0, 16'h0000, 0, 3, 3, 1);
    step(1, 0, 0, 16'h0000, 0, 3, 3, 1);

    // Fill under stall, fifth offer waits for the drain to resume.
    for (int i = 1; i <= 5; i++) step(1, 1, 5'(i), 16'(i * 16'h111), 1, 2, 4, 1);
    step(1, 1, 5, 16'h0555, 0, 2, 4, 1);
    step(1, 1, 5, 16'h0555, 0, 2, 5, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 5, 1, 1);

    // Forward priority among same-index entries.
    step(1, 1, 5, 16'd1, 1, 5, 0, 1);
    step(1, 1, 5, 16'd2, 1, 5, 0, 1);
    step(1, 1, 5, 16'd3, 1, 5, 0, 1);
    step(1, 0, 0, 0,     1, 5, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 5, 0, 1);

    // Forward from the write stage only.
    step(1, 1, 7, 16'h00FF, 0, 0, 7, 1);
    step(1, 0, 0, 0, 0, 0, 7, 1);
    step(1, 0, 0, 0, 0, 0, 7, 1);
    step(1, 0, 0, 0, 0, 0, 7, 1);

    // Steady occupancy of two with concurrent push/pop; pointers wrap.
    step(1, 1, 10, 16'h1000, 1, 10, 11, 1);
    step(1, 1, 11, 16'h1001, 1, 10, 11, 1);
    for (int i = 0; i < 10; i++)
      step(1, 1, 5'(12 + i), 16'(16'h2000 + i), 0, 5'(12 + i), 5'(11 + i), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 20, 21, 1);

    // Reset while entries are pending and one is draining.
    step(1, 1, 1, 16'hBEEF, 1, 1, 2, 1);
    step(1, 1, 2, 16'hCAFE, 1, 1, 2, 1);
    step(1, 1, 1, 16'hF00D, 0, 1, 2, 1);
    step(0, 0, 0, 0, 0, 1, 2, 1);
    step(1, 0, 0, 0, 0, 1, 2, 1);
    step(1, 0, 0, 0, 0, 1, 2, 1);

    // Random traffic over a small index range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 3)),
           16'($urandom),
           ($urandom_range(0, 9) < 3),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries (power of two, min 2).
REQ-002 Parameter: DATA_W, 16, register data width.
REQ-003 Parameter: ADDR_W, 5, register index width.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-low.
REQ-006 Port: res_valid  input  1  execute stage offers a result.
REQ-007 Port: res_ready  output  1  queue accepts a result this cycle.
REQ-008 Port: res_rd  input  ADDR_W  destination register of offered result.
REQ-009 Port: res_data  input  DATA_W  offered result value.
REQ-010 Port: wr_stall  input  1  register bank write port busy; hold drain.
REQ-011 Port: we  output  1  write enable to register bank (registered).
REQ-012 Port: rd  output  ADDR_W  write index to register bank (registered).
REQ-013 Port: wd  output  DATA_W  write data to register bank (registered).
REQ-014 Port: ra, rb  input  ADDR_W each  operand indices being read from the bank.
REQ-015 Port: fwd_a_hit, fwd_b_hit  output  1 each  pending write exists for ra / rb.
REQ-016 Port: fwd_a_data, fwd_b_data  output  DATA_W each  youngest pending value for ra / rb.
REQ-017 Port: count  output  clog2(DEPTH)+1  entries held in queue (excludes write stage).

Function
REQ-018 Push SHALL occur on an edge where res_valid && res_ready; entry {res_rd, res_data} written at tail.
REQ-019 res_ready SHALL equal (count < DEPTH), combinational from registered count only; no same-cycle full bypass.
REQ-020 Drain: on each edge with count != 0 and wr_stall == 0, head SHALL pop and load we<=1, rd<=head.rd, wd<=head.data.
REQ-021 On edges with count == 0 or wr_stall == 1, we SHALL load 0; rd/wd SHALL hold previous values.
REQ-022 Latency: result pushed at edge N SHALL appear on we/rd/wd after edge N+1 at earliest (queue empty, no stall).
REQ-023 Writes SHALL leave in push order; no reordering or merging of same-index entries.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 Push when full SHALL not occur (res_ready=0); res_valid held high while full SHALL be accepted on first edge count < DEPTH.
REQ-026 Forwarding search SHALL be combinational over queue entries plus the write stage (when we=1), which the bank has not yet committed.
REQ-027 On multiple matches, fwd_x_data SHALL come from youngest entry (tail-most queue entry, write stage oldest).
REQ-028 No match SHALL give fwd_x_hit=0, fwd_x_data=0; the offered res_* input SHALL NOT participate in matching.

Reset
REQ-029 rst low at an edge SHALL set count=0, head=tail=0, we=0, rd=0, wd=0, discarding pending entries, including mid-drain.
REQ-030 Entry storage need not be reset; forwarding SHALL only consider valid entries, so hits are 0 after reset.
REQ-031 res_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-032 DATA_W, ADDR_W, DEPTH defaults and the {rd, data} entry record SHALL live in the shared processor package with the register-bank constants.
REQ-033 Priority match logic SHALL be one sub-module, wbq_fwd_match, instantiated twice (ports a, b).
REQ-034 Queue storage and pointers SHALL be in reg_wb_queue; no other sub-modules.

Verification
REQ-035 Single write: push {rd=3, data=16'hA5A5} at edge 0 -> we=1, rd=3, wd=16'hA5A5 after edge 1 only; count 1 then 0.
REQ-036 Fill: 5 back-to-back pushes with wr_stall=1 -> res_ready=0 after 4th, count=4, 5th accepted one edge after stall drops.
REQ-037 Forward priority: push r5=1, r5=2, r5=3 under stall, ra=5 -> fwd_a_hit=1, fwd_a_data=3; drain all -> hit=0.
REQ-038 Write-stage forward: single push r7=16'h00FF, rb=7 during the cycle we=1 -> fwd_b_hit=1, data 16'h00FF; next cycle hit=0.
REQ-039 Wrap/concurrency: 10 pushes interleaved with pops, count steady at 2 -> in-order writes, pointers wrap, no loss.
REQ-040 Reset mid-drain: 3 entries queued, rst=0 one edge -> we=0, count=0, hits=0, res_ready=1 next cycle.
